// File: rtl/bubble_sort_ctrl.sv
// Sequential bubble-sort engine: one shared compare-exchange pass per clock over a DIM-element register array.
// Optional early exit on a swap-free pass is enabled by defining BUBBLE_SORT_EARLY_EXIT_EN.
module bubble_sort_ctrl #(
  parameter int DIM   = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIM*WIDTH-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM*WIDTH-1:0]     out_data,
  output logic [$clog2(DIM)-1:0]   passes,
  output logic                     busy
);

  localparam int KW = $clog2(DIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] arr      [DIM];
  logic [WIDTH-1:0] pass_arr [DIM];
  logic [WIDTH-1:0] tmp;
  logic [KW-1:0]    pass_k;
  logic             load;
  logic             step;
  logic             last_pass;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  logic             swapped;
`endif

  // One bubble pass k: in-order compare-exchange chain, pairs beyond DIM-1-k masked off.
  always_comb begin
    // NOTE: blocking assignments are intentional here; each exchange must see the
    // result of the previous one so the largest element bubbles through the chain.
    for (int i = 0; i < DIM; i++) begin
      pass_arr[i] = arr[i];
    end
    tmp = '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    swapped = 1'b0;
`endif
    for (int j = 0; j < DIM - 1; j++) begin
      if ((j + int'(pass_k) <= DIM - 1) && (pass_arr[j] > pass_arr[j+1])) begin
        tmp           = pass_arr[j];
        pass_arr[j]   = pass_arr[j+1];
        pass_arr[j+1] = tmp;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        swapped       = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    last_pass  = (pass_k == KW'(DIM - 1));
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          load       = 1'b1;
          next_state = SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        step = 1'b1;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        if (last_pass || !swapped) begin
          next_state = DONE;
        end
`else
        if (last_pass) begin
          next_state = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array doubles as the visible result, so it is reset to give
      // a defined out_data of zero and to discard any partially sorted data.
      for (int i = 0; i < DIM; i++) begin
        arr[i] <= '0;
      end
      pass_k <= KW'(1);
      passes <= '0;
    end else if (load) begin
      for (int i = 0; i < DIM; i++) begin
        arr[i] <= in_data[WIDTH*i +: WIDTH];
      end
      pass_k <= KW'(1);
      passes <= '0;
    end else if (step) begin
      for (int i = 0; i < DIM; i++) begin
        arr[i] <= pass_arr[i];
      end
      pass_k <= pass_k + KW'(1);
      passes <= passes + KW'(1);
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < DIM; i++) begin
      out_data[WIDTH*i +: WIDTH] = arr[i];
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Scoreboard bench for bubble_sort_ctrl (DIM=8, WIDTH=8); follows BUBBLE_SORT_EARLY_EXIT_EN if defined.
module tb_bubble_sort_ctrl;

  localparam int DIM   = 8;
  localparam int WIDTH = 8;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [2:0]  passes;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  passes;
  logic        busy;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int unsigned cyc     = 0;

  bubble_sort_ctrl #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .passes    (passes),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Element 0 is the first argument.
  function automatic logic [63:0] mk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [63:0] ref_sort(input logic [63:0] d);
    logic [7:0] a [8];
    logic [7:0] v;
    logic [63:0] r;
    int k;
    for (int i = 0; i < 8; i++) a[i] = d[8*i +: 8];
    for (int i = 1; i < 8; i++) begin
      v = a[i];
      k = i - 1;
      while (k >= 0 && a[k] > v) begin
        a[k+1] = a[k];
        k--;
      end
      a[k+1] = v;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = a[i];
    return r;
  endfunction

  // Bubble passes needed = max count of strictly larger predecessors; early exit adds one clean pass.
  function automatic logic [2:0] ref_passes(input logic [63:0] d);
    int mx;
    int c;
    int p;
    mx = 0;
    for (int i = 0; i < 8; i++) begin
      c = 0;
      for (int m = 0; m < i; m++) begin
        if (d[8*m +: 8] > d[8*i +: 8]) c++;
      end
      if (c > mx) mx = c;
    end
    p = EARLY ? mx + 1 : 7;
    if (p > 7) p = 7;
    return p[2:0];
  endfunction

  // Monitor: pop and compare on every accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("sort_data", out_data, e.data);
          check("sort_passes", 64'(passes), 64'(e.passes));
        end
      end
    end
  end

  // Called at #1 after a posedge; returns #1 after the accepting edge.
  task automatic accept(input logic [63:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] exp_d, input logic [2:0] exp_p);
    int lat;
    exp_t e;
    e.data   = exp_d;
    e.passes = exp_p;
    sb.push_back(e);
    accept(d);
    wait_valid(lat);
    check("latency", 64'(lat), 64'(exp_p));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rev, srt, dup, dup_s, rs_in, rs_s, d;
    logic [63:0] b2b [3];
    logic [2:0]  b2b_p [3];
    int unsigned acc_cyc [3];
    int lat;
    int n;

    rev   = mk(7, 6, 5, 4, 3, 2, 1, 0);
    srt   = mk(10, 20, 30, 40, 50, 60, 70, 80);
    dup   = mk(255, 0, 3, 3, 255, 1, 0, 3);
    dup_s = mk(0, 0, 1, 3, 3, 3, 255, 255);
    rs_in = mk(5, 4, 3, 2, 1, 0, 9, 8);
    rs_s  = mk(0, 1, 2, 3, 4, 5, 8, 9);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_passes", 64'(passes), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors
    send(rev, mk(0, 1, 2, 3, 4, 5, 6, 7), 3'd7);
    send(srt, srt, EARLY ? 3'd1 : 3'd7);
    send(dup, dup_s, EARLY ? 3'd6 : 3'd7);

    // Backpressure in DONE
    out_ready = 1'b0;
    begin
      exp_t e;
      e.data = mk(0, 1, 2, 3, 4, 5, 6, 7);
      e.passes = 3'd7;
      sb.push_back(e);
    end
    accept(rev);
    check("busy_in_sort", 64'(busy), 64'd1);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd7);
    in_valid = 1'b1;
    in_data  = srt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_data", out_data, mk(0, 1, 2, 3, 4, 5, 6, 7));
      check("bp_passes", 64'(passes), 64'd7);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Reset after pass 3
    accept(rev);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("mid_passes", 64'(passes), 64'd3);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_passes", 64'(passes), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready_idle", 64'(in_ready), 64'd1);
    check("mid_rst_out_data", out_data, 64'd0);
    send(rs_in, rs_s, EARLY ? 3'd6 : 3'd7);

    // Back-to-back with in_valid held high
    b2b[0] = rev;  b2b_p[0] = 3'd7;
    b2b[1] = srt;  b2b_p[1] = EARLY ? 3'd1 : 3'd7;
    b2b[2] = dup;  b2b_p[2] = EARLY ? 3'd6 : 3'd7;
    begin
      exp_t e;
      e.data = mk(0, 1, 2, 3, 4, 5, 6, 7); e.passes = b2b_p[0]; sb.push_back(e);
      e.data = srt;   e.passes = b2b_p[1]; sb.push_back(e);
      e.data = dup_s; e.passes = b2b_p[2]; sb.push_back(e);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = b2b[i];
      n = 0;
      while (!in_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("b2b_in_ready_wait", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      acc_cyc[i] = cyc;
    end
    in_valid = 1'b0;
    check("b2b_spacing0", 64'(acc_cyc[1] - acc_cyc[0]), 64'(b2b_p[0]) + 64'd2);
    check("b2b_spacing1", 64'(acc_cyc[2] - acc_cyc[1]), 64'(b2b_p[1]) + 64'd2);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Randomized arrays against the reference sort
    for (int t = 0; t < 1000; t++) begin
      d = {$urandom, $urandom};
      if (t % 3 == 1) d = d & 64'h0303_0303_0303_0303;
      if (t % 7 == 2) d = ref_sort(d);
      send(d, ref_sort(d), ref_passes(d));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bubble_sort_ctrl.md
# bubble_sort_ctrl

Sequential bubble-sort engine that owns one DIM-element register array and applies one bubble pass per clock until the array is sorted. It replaces the fully unrolled chain of DIM-1 combinational passes with a single pass datapath sequenced by a small state machine, which trades latency for area. Packed vectors and a valid/ready handshake on both sides let it sit directly between a producer and a consumer of packed arrays.

## Interface
- DIM, 8: number of elements; legal range 2..64
- WIDTH, 8: element width in bits; elements are unsigned
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds an array to sort
- in_ready  out  1  block can accept an array
- in_data  in  DIM*WIDTH  element j at bits [WIDTH*(j+1)-1 : WIDTH*j]
- out_valid  out  1  out_data holds the sorted array
- out_ready  in  1  consumer accepts the result
- out_data  out  DIM*WIDTH  sorted array in the same packing, element 0 smallest
- passes  out  $clog2(DIM)  number of passes executed for the current result
- busy  out  1  high in SORT

## Operation
- States: IDLE, SORT, DONE. Reset puts the block in IDLE. Reset values: out_valid=0, busy=0, out_data=0, passes=0, pass counter=1. in_ready=0 while rst is high.
- IDLE: in_ready=1. On in_valid&&in_ready, the block captures in_data into the array, sets the pass counter k=1 and passes=0, and moves to SORT.
- SORT: once per cycle it applies pass k to the array. Pass k is an in-order compare-exchange chain over index pairs (j, j+1) for j = 0..DIM-1-k. It swaps only when elem[j] > elem[j+1] (unsigned, strict), so equal elements never move. After pass k, index DIM-k holds its final value. Each pass increments passes and k.
- SORT to DONE: after the pass with k==DIM-1. It also moves to DONE on the early-exit condition (see Configuration).
- DONE: out_valid=1. out_data and passes are held stable. On out_ready, the block goes to IDLE with out_valid=0 on the next cycle. in_ready stays 0 in DONE, so a new input cannot overwrite an unconsumed result.
- No input is accepted in SORT or DONE. in_valid is ignored there.
- rst in any state aborts the operation at the next edge and returns all outputs to their reset values. A partially sorted array is discarded.
- The array register is the only datapath storage. Comparators and muxes for one pass are shared across all k; index bounds are masked by k.

## Timing
- Input accepted at edge N. Pass k completes at edge N+k.
- Without early exit: out_valid rises after edge N+DIM-1, giving DIM-1 cycles of latency, and passes=DIM-1.
- With early exit: out_valid rises after edge N+p, where p is the first pass that performs no swap or p=DIM-1, whichever comes first; passes=p.
- Result accepted at edge M (out_valid&&out_ready). in_ready=1 from edge M+1. Back-to-back throughput is one array per latency+2 cycles.
- There are no combinational paths from in_valid or out_ready to any output.

## Configuration
- Macro: BUBBLE_SORT_EARLY_EXIT_EN.
- Defined: the pass datapath produces a swap flag. A pass with no swap moves SORT to DONE, and passes reports the count including that pass. A sorted input therefore completes in 1 pass.
- Undefined: the swap flag logic is absent, and every array always takes exactly DIM-1 passes.
- out_data is identical in both builds.

## Test plan
- Reverse order, DIM=8, WIDTH=8: input elements 0..7 = 7,6,5,4,3,2,1,0 -> out_data 0..7 = 0,1,...,7; passes=7; out_valid 7 cycles after accept in both builds.
- Already sorted input 0..7 = 10,20,...,80 -> out_data unchanged. With the macro defined: passes=1 and out_valid 1 cycle after accept. Without it: passes=7.
- Duplicates and extremes: input 255,0,3,3,255,1,0,3 -> 0,0,1,3,3,3,255,255. A randomized pass compares against a reference sort for 1000 arrays.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data and passes stable, in_ready=0, in_valid ignored. out_ready=1 -> in_ready=1 on the following cycle.
- Reset mid-sort: assert rst for one cycle after pass 3 -> next cycle state is IDLE, out_valid=0, passes=0. A new array 5,4,3,2,1,0,9,8 then sorts to 0,1,2,3,4,5,8,9.
- Back-to-back: out_ready tied high, in_valid high with 3 different arrays -> each result is correct and appears in order. Arrays are accepted only in IDLE, with spacing of latency+2 cycles.
